// File: rtl/core_pkg.sv
// Opcode constants and decode types shared by the pipelined core.
package core_pkg;

  localparam logic [6:0] OPCODE_LOAD   = 7'h03;
  localparam logic [6:0] OPCODE_OP_IMM = 7'h13;
  localparam logic [6:0] OPCODE_STORE  = 7'h23;
  localparam logic [6:0] OPCODE_OP     = 7'h33;
  localparam logic [6:0] OPCODE_LUI    = 7'h37;
  localparam logic [6:0] OPCODE_BRANCH = 7'h63;
  localparam logic [6:0] OPCODE_JALR   = 7'h67;
  localparam logic [6:0] OPCODE_JAL    = 7'h6F;
  localparam logic [6:0] OPCODE_SYSTEM = 7'h73;

  typedef struct packed {
    logic regWrite;
    logic memWrite;
    logic mem2reg;
    logic illegal;
  } ctrl_t;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

endpackage

// File: rtl/rf_bypass.sv
// Two-read, one-write register file: posedge write, x0 hardwired to zero,
// optional same-cycle write-to-read bypass.
module rf_bypass #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = $clog2(NREGS),
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [AW-1:0]   raddr1_i,
  input  logic [AW-1:0]   raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  logic [XLEN-1:0] mem_q [NREGS];

  // NOTE: reset clears every entry so all registers read 0 out of reset; this
  // makes the array plain flops rather than something a RAM macro could absorb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (we_i && waddr_i != '0) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == '0)                          ? '0      :
                    (BYPASS && we_i && raddr1_i == waddr_i)   ? wdata_i :
                                                                mem_q[raddr1_i];
  assign rdata2_o = (raddr2_i == '0)                          ? '0      :
                    (BYPASS && we_i && raddr2_i == waddr_i)   ? wdata_i :
                                                                mem_q[raddr2_i];

endmodule

// File: rtl/decode_pipe.sv
// Decode stage: control/immediate decode, register read, load-use hazard
// detection and a stallable, flushable D->E pipeline register.
module decode_pipe
  import core_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     validD,
  output logic                     readyD,
  input  logic [XLEN-1:0]          pcD,
  input  logic [XLEN-1:0]          instrD,
  input  logic                     flush,
  input  logic                     regWriteW,
  input  logic [$clog2(NREGS)-1:0] rdW,
  input  logic [XLEN-1:0]          resultW,
  output logic                     validE,
  input  logic                     readyE,
  output logic [XLEN-1:0]          rdata1E,
  output logic [XLEN-1:0]          rdata2E,
  output logic [XLEN-1:0]          immE,
  output logic [XLEN-1:0]          pcE,
  output logic [$clog2(NREGS)-1:0] rs1E,
  output logic [$clog2(NREGS)-1:0] rs2E,
  output logic [$clog2(NREGS)-1:0] rdE,
  output logic                     regWriteE,
  output logic                     memWriteE,
  output logic                     mem2regE,
  output logic                     illegalE
);

  localparam int AW = $clog2(NREGS);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [XLEN-1:0] imm;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    ctrl_t           ctrl;
  } ereg_t;

  logic [6:0]      opcode;
  ctrl_t           ctrl;
  imm_fmt_e        imm_fmt;
  logic            uses_rs1, uses_rs2;
  logic [31:0]     imm32;
  logic [AW-1:0]   rs1, rs2, rd;
  logic [XLEN-1:0] rdata1, rdata2;
  logic            hazard;
  ereg_t           e_q, e_d;

  assign opcode = instrD[6:0];
  assign rs1    = instrD[15 +: AW];
  assign rs2    = instrD[20 +: AW];
  assign rd     = instrD[7 +: AW];

  // NOTE: every output of this block gets a default before the case, so no
  // opcode path can leave one unassigned and infer a latch.
  always_comb begin
    ctrl     = '0;
    imm_fmt  = IMM_NONE;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (opcode)
      OPCODE_LOAD:   begin ctrl.regWrite = 1'b1; ctrl.mem2reg = 1'b1; imm_fmt = IMM_I; end
      OPCODE_STORE:  begin ctrl.memWrite = 1'b1; imm_fmt = IMM_S; uses_rs2 = 1'b1; end
      OPCODE_OP:     begin ctrl.regWrite = 1'b1; uses_rs2 = 1'b1; end
      OPCODE_OP_IMM: begin ctrl.regWrite = 1'b1; imm_fmt = IMM_I; end
      OPCODE_LUI:    begin ctrl.regWrite = 1'b1; imm_fmt = IMM_U; uses_rs1 = 1'b0; end
      OPCODE_JAL:    begin ctrl.regWrite = 1'b1; imm_fmt = IMM_J; uses_rs1 = 1'b0; end
      OPCODE_JALR:   begin ctrl.regWrite = 1'b1; imm_fmt = IMM_I; end
      OPCODE_BRANCH: begin imm_fmt = IMM_B; uses_rs2 = 1'b1; end
      OPCODE_SYSTEM: begin imm_fmt = IMM_I; end
      default:       begin ctrl.illegal = 1'b1; uses_rs1 = 1'b0; end
    endcase
  end

  always_comb begin
    case (imm_fmt)
      IMM_I:   imm32 = {{20{instrD[31]}}, instrD[31:20]};
      IMM_S:   imm32 = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
      IMM_B:   imm32 = {{19{instrD[31]}}, instrD[31], instrD[7], instrD[30:25], instrD[11:8], 1'b0};
      IMM_U:   imm32 = {instrD[31:12], 12'h000};
      IMM_J:   imm32 = {{11{instrD[31]}}, instrD[31], instrD[19:12], instrD[20], instrD[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  rf_bypass #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .AW     (AW),
    .BYPASS (BYPASS)
  ) u_rf (
    .clk      (clk),
    .rst_n    (reset),
    .we_i     (regWriteW),
    .waddr_i  (rdW),
    .wdata_i  (resultW),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2)
  );

  // A load in E whose destination feeds D cannot be forwarded in time.
  assign hazard = validD && e_q.valid && e_q.ctrl.mem2reg && (e_q.rd != '0) &&
                  ((uses_rs1 && rs1 == e_q.rd) || (uses_rs2 && rs2 == e_q.rd));

  always_comb begin
    e_d    = e_q;
    readyD = 1'b1;
    if (flush) begin
      e_d = '0;
    end else if (e_q.valid && !readyE) begin
      readyD = 1'b0;
    end else if (hazard) begin
      e_d    = '0;
      readyD = 1'b0;
    end else if (validD) begin
      e_d.valid  = 1'b1;
      e_d.pc     = pcD;
      e_d.rdata1 = rdata1;
      e_d.rdata2 = rdata2;
      e_d.imm    = XLEN'($signed(imm32));
      e_d.rs1    = rs1;
      e_d.rs2    = rs2;
      e_d.rd     = rd;
      e_d.ctrl   = ctrl;
    end else begin
      e_d = '0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) e_q <= '0;
    else        e_q <= e_d;
  end

  assign validE    = e_q.valid;
  assign pcE       = e_q.pc;
  assign rdata1E   = e_q.rdata1;
  assign rdata2E   = e_q.rdata2;
  assign immE      = e_q.imm;
  assign rs1E      = e_q.rs1;
  assign rs2E      = e_q.rs2;
  assign rdE       = e_q.rd;
  assign regWriteE = e_q.ctrl.regWrite;
  assign memWriteE = e_q.ctrl.memWrite;
  assign mem2regE  = e_q.ctrl.mem2reg;
  assign illegalE  = e_q.ctrl.illegal;

endmodule

// File: doc/decode_pipe.md
# decode_pipe

Parametrised decode stage with valid/ready flow control, flush, load-use hazard detection and write-back bypass. Sits between fetch and execute in the pipelined core. Decodes the instruction into control bits and immediate, reads an internal register file, and holds the results in a stallable D→E pipeline register. It replaces the free-running decode register and the negedge-written register file, so mid-cycle register writes are no longer needed.

## Interface
- `XLEN`, 32: data and instruction word width.
- `NREGS`, 32: architectural register count, power of two; `AW = $clog2(NREGS)`.
- `BYPASS`, 1: 1 enables the write-back→read bypass; 0 makes a same-cycle write visible only on the next cycle.

Ports:
- `clk`  in  1  clock; all state is posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `validD`  in  1  fetch presents an instruction.
- `readyD`  out  1  decode accepts the instruction this cycle.
- `pcD`, `instrD`  in  XLEN  instruction address and word.
- `flush`  in  1  execute redirected; kill the E register and discard D.
- `regWriteW`  in  1  write-back enable.
- `rdW`  in  AW  write-back destination.
- `resultW`  in  XLEN  write-back data.
- `validE`  out  1  E register holds a live instruction.
- `readyE`  in  1  execute accepts the E register contents.
- `rdata1E`, `rdata2E`, `immE`, `pcE`  out  XLEN  operands, immediate and PC.
- `rs1E`, `rs2E`, `rdE`  out  AW  register indices, used by forwarding.
- `regWriteE`, `memWriteE`, `mem2regE`, `illegalE`  out  1  control bits.

## Operation
- **Control decode** per opcode:
  - LOAD sets `regWrite` and `mem2reg`.
  - STORE sets `memWrite`.
  - OP, OP_IMM, LUI, JAL and JALR set `regWrite`.
  - BRANCH and SYSTEM set none of the three.
  - Any other opcode sets `illegal=1` and all other control bits 0. No simulation messages.
- **Immediate** uses the I, S, B, U and J formats as defined for the core. Illegal opcodes and opcodes without an immediate produce 0; the output is never x.
- **Operand use:**
  - `uses_rs1` is 0 for LUI, JAL and illegal opcodes, and 1 otherwise.
  - `uses_rs2` is 1 for OP, STORE and BRANCH only.
- **Register file:**
  - Written at posedge when `regWriteW && rdW != 0`.
  - Register 0 always reads 0.
  - With `BYPASS=1`, a read whose index equals the `rdW` being written returns `resultW` combinationally.
- **Load-use hazard:** `hazard = validD & validE & mem2regE & rdE != 0 & ((uses_rs1 & rs1D == rdE) | (uses_rs2 & rs2D == rdE))`.
- **E-register update**, in priority order:
  1. `flush`: `validE <= 0`, D is discarded, `readyD = 1`.
  2. `validE & !readyE`: hold all E outputs, `readyD = 0`.
  3. `hazard`: insert a bubble (`validE <= 0`), `readyD = 0`, D is held by fetch.
  4. Otherwise: capture the decoded D, `validE <= validD`, `readyD = 1`.
- **Bubbles** (`validE = 0`) also clear `regWriteE` and `memWriteE`. Consumers may therefore ignore `validE` for side effects.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears on the E outputs after edge N.
- `readyD` is combinational from `validD`, `instrD`, `flush`, `readyE` and the E state. `readyD` never depends on itself.
- A load-use stall lasts exactly one cycle when `readyE=1`. The bubble breaks the match on the next cycle.
- `flush` asserted together with `hazard` or `!readyE`: flush wins.
- Reset while asserted:
  - All E outputs are 0.
  - `validE=0`, `illegalE=0`.
  - All registers read 0.
  - Takes effect without a clock edge.
- Reset mid-stall: after release, the stage restarts empty and `readyD=1`.
- A write-back to the same register as a D read in the same cycle:
  - `BYPASS=1`: the new value is captured.
  - `BYPASS=0`: the old value is captured.

## Structure
- **Shared package `core_pkg`:**
  - `OPCODE_*` constants.
  - `ctrl_t` struct with fields `regWrite`, `memWrite`, `mem2reg`, `illegal`.
  - Immediate-format enum.
- **Sub-module `rf_bypass`:** posedge-write register file, x0 hardwired to 0, async-reset clear, `BYPASS` parameter.
- Decode logic and hazard logic stay in `decode_pipe`.

## Test plan
- **Plain decode:** `instrD=0x00500093` (addi x1,x0,5), `pcD=0x100`, `validD=1` → next cycle `validE=1`, `immE=5`, `rdE=1`, `regWriteE=1`, `pcE=0x100`.
- **Load-use stall:** `lw x2,0(x1)` followed by `add x3,x2,x2` → exactly one cycle with `readyD=0` and a bubble (`validE=0`); the add appears in E on the following cycle. A repeat with `add x3,x4,x4` shows no stall.
- **Write-back bypass:** `regWriteW=1`, `rdW=7`, `resultW=0xDEADBEEF` in the same cycle as decode of `add x1,x7,x0` → `rdata1E=0xDEADBEEF` with `BYPASS=1`, 0 with `BYPASS=0`.
- **Back-pressure:** hold `readyE=0` for 3 cycles with a valid E → E outputs are stable and `readyD=0` throughout. Release → the next instruction is captured.
- **Flush priority:** `flush=1` while a hazard and `readyE=0` are both present → `validE=0` next cycle, `readyD=1`.
- **Reset and x0 rules:**
  - Async `reset=0` mid-stream → `validE` drops before the next edge.
  - After release, a write to x0 with `resultW=5` → x0 still reads 0.
  - Opcode `0x7F` → `illegalE=1`, `regWriteE=0`, `memWriteE=0`.
